poly_add_mod_q: RTL and testbench

- Streaming coefficient-wise polynomial adder for the Kyber768 encapsulation datapath (e.g. u = A^T·r + e1, v = t^T·r + e2 + m).
- Consumes pairs of 12-bit coefficients, forms the 13-bit sum with the cla_adder, reduces it mod q = 3329 by one conditional subtraction, and emits 12-bit coefficients.
- Two-stage valid/ready pipeline with backpressure; counts coefficients and flags the last of each 256-coefficient polynomial.

---
 rtl/kyber_pkg.sv | 10 +
 rtl/cla_adder.sv | 46 ++++
 rtl/mod_q_csub.sv | 10 +
 rtl/poly_add_mod_q.sv | 106 ++++++++++
 tb/tb_poly_add_mod_q.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Kyber ring constants and coefficient types shared by the polynomial datapath.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEFF_W = 12;
  localparam int IDX_W   = $clog2(KYBER_N);

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [COEFF_W:0]   sum_t;
endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups chained group to group.
module cla_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int NBLK = (WIDTH + 3) / 4;
  localparam int PW   = NBLK * 4;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;
  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;

  assign w_a = PW'(i_a);
  assign w_b = PW'(i_b);
  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Each group carry is a flat sum-of-products of its own g/p and the group carry-in.
  always_comb begin
    logic [PW:0] c;
    logic        acc;
    logic        term;
    c    = '0;
    c[0] = i_cin;
    for (int blk = 0; blk < NBLK; blk++) begin
      for (int j = 1; j <= 4; j++) begin
        acc = c[blk*4];
        for (int k = 0; k < j; k++) acc = acc & w_p[blk*4+k];
        for (int k = 0; k < j; k++) begin
          term = w_g[blk*4+k];
          for (int m = k + 1; m < j; m++) term = term & w_p[blk*4+m];
          acc = acc | term;
        end
        c[blk*4+j] = acc;
      end
    end
    o_sum  = w_p[WIDTH-1:0] ^ c[WIDTH-1:0];
    o_cout = c[WIDTH];
  end
endmodule

// File: rtl/mod_q_csub.sv
// Single conditional subtraction of q from a 13-bit coefficient sum.
module mod_q_csub
  import kyber_pkg::*;
(
  input  sum_t   i_sum,
  output coeff_t o_coeff
);
  // Sums of two reduced coefficients are below 2q, so one subtraction fully reduces them.
  assign o_coeff = coeff_t'((i_sum >= sum_t'(KYBER_Q)) ? (i_sum - sum_t'(KYBER_Q)) : i_sum);
endmodule

// File: rtl/poly_add_mod_q.sv
// Two-stage streaming coefficient adder mod q with per-polynomial index and last flag.
// Optional sticky input range flag enabled by defining POLY_ADD_RANGE_CHK_EN.
module poly_add_mod_q
  import kyber_pkg::*;
#(
  parameter int DATA_WID = COEFF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_coeff,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last
`ifdef POLY_ADD_RANGE_CHK_EN
  ,
  output logic                range_err
`endif
);
  logic                r_s1_valid;
  logic [DATA_WID:0]   r_sum1;
  logic                r_s2_valid;
  logic [DATA_WID-1:0] r_out_coeff;
  logic [IDX_W-1:0]    r_out_idx;

  logic                w_s1_adv;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [DATA_WID-1:0] w_sum_lo;
  logic                w_sum_cout;
  logic [DATA_WID-1:0] w_reduced;

  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  cla_adder #(.WIDTH(DATA_WID)) u_cla_adder (
    .i_a    (in1),
    .i_b    (in2),
    .i_cin  (1'b0),
    .o_sum  (w_sum_lo),
    .o_cout (w_sum_cout)
  );

  mod_q_csub u_mod_q_csub (
    .i_sum   (r_sum1),
    .o_coeff (w_reduced)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_sum1     <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_sum1     <= {w_sum_cout, w_sum_lo};
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 refills in the same cycle it drains, so a full pipe never bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_coeff <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid  <= 1'b1;
      r_out_coeff <= w_reduced;
    end else if (w_out_xfer) begin
      r_s2_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_idx <= '0;
    end else if (w_out_xfer) begin
      r_out_idx <= (r_out_idx == IDX_W'(KYBER_N - 1)) ? '0 : r_out_idx + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_coeff = r_out_coeff;
  assign out_idx   = r_out_idx;
  assign out_last  = r_s2_valid && (r_out_idx == IDX_W'(KYBER_N - 1));

`ifdef POLY_ADD_RANGE_CHK_EN
  logic r_range_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if (w_in_xfer && ((in1 >= DATA_WID'(KYBER_Q)) || (in2 >= DATA_WID'(KYBER_Q)))) begin
      r_range_err <= 1'b1;
    end
  end

  assign range_err = r_range_err;
`endif
endmodule

// File: tb/tb_poly_add_mod_q.sv
// Randomized scoreboard bench for poly_add_mod_q; expected values come from plain modular arithmetic.
module tb_poly_add_mod_q;
  localparam int Q = 3329;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in1 = '0;
  logic [11:0] in2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_coeff;
  logic [7:0]  out_idx;
  logic        out_last;
`ifdef POLY_ADD_RANGE_CHK_EN
  logic        range_err;
`endif

  poly_add_mod_q dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef POLY_ADD_RANGE_CHK_EN
    ,
    .range_err (range_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int coeff;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  int   last_cnt = 0;
  int   model_idx = 0;
  bit   lat_chk = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   send_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_add(input int a, input int b);
    int s;
    s = a + b;
    if (a < Q && b < Q) return s % Q;
    return (s >= Q ? s - Q : s) % 4096;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected results are queued at acceptance time.
  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      sb_q.push_back('{ref_add(int'(in1), int'(in2)), cyc});
      acc_cnt++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got coeff %0d, expected no output", out_coeff);
        end else begin
          e = sb_q.pop_front();
          check("out_coeff", out_coeff, e.coeff);
          check("out_idx", out_idx, model_idx);
          check("out_last", out_last, (model_idx == N - 1) ? 1 : 0);
          if (lat_chk) check("latency", cyc - e.cyc, 2);
          if (out_cnt == N) check("idx_after_wrap", out_idx, 0);
          if (out_last) last_cnt++;
          model_idx = (model_idx + 1) % N;
          out_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    in1 = 12'(a);
    in2 = 12'(b);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    model_idx = 0;
    out_cnt = 0;
    last_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc_base;
    logic [11:0] cap_c;
    logic [7:0]  cap_i;
    bit          seen;
    int          n;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_coeff", out_coeff, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic and modular wrap, back-to-back with latency tracking
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(10, 20);
    send(0, 0);
    send(256, 0);
    send(3328, 3328);
    send(3328, 1);
    send(1664, 1665);
    wait_drain();
    lat_chk = 1'b0;

    // backpressure: two accepted, then stall with a stable output
    out_ready = 1'b0;
    acc_base = acc_cnt;
    send_done = 1'b0;
    fork
      begin
        send(100, 200);
        send(3000, 328);
        send(1, 2);
        send(3328, 2);
        send_done = 1'b1;
      end
    join_none
    seen = 1'b0;
    cap_c = '0;
    cap_i = '0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          cap_c = out_coeff;
          cap_i = out_idx;
          seen = 1'b1;
        end else begin
          check("stall_coeff_stable", out_coeff, cap_c);
          check("stall_idx_stable", out_idx, cap_i);
        end
      end
    end
    check("stall_accepts", acc_cnt - acc_base, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (!send_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_sends_done", send_done, 1);
    @(posedge clk);
    #1;
    wait_drain();

    // full polynomial with random gaps on both sides
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < N + 1; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("poly_out_count", out_cnt, N + 1);
    check("poly_last_count", last_cnt, 1);

    // asynchronous reset with both stages full
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
    wait_drain();
    check("pre_rst_out_count", out_cnt, 100);
    out_ready = 1'b0;
    send(11, 22);
    send(33, 44);
    #1;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst = 1'b1;
    sb_q.delete();
    model_idx = 0;
    out_cnt = 0;
    last_cnt = 0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_idx", out_idx, 0);
    check("async_rst_out_last", out_last, 0);
    check("async_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(7, 8);
    wait_drain();
    check("post_rst_out_count", out_cnt, 1);

`ifdef POLY_ADD_RANGE_CHK_EN
    do_reset();
    send(5, 6);
    check("range_err_clean", range_err, 0);
    send(3329, 0);
    check("range_err_set", range_err, 1);
    send(1, 2);
    send(100, 100);
    check("range_err_sticky", range_err, 1);
    wait_drain();
    do_reset();
    check("range_err_cleared", range_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
